// File: rtl/bpfcap_dma_engine_if.sv
// Bus bundle for the DMA engine: CSR slave port plus Avalon-MM read and write masters.
// The master modport is the engine's view; slave is the host/memory side.
`timescale 1ns/1ps
interface bpfcap_dma_engine_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic [2:0]        avs_s0_address;
    logic [31:0]       avs_s0_writedata;
    logic              avs_s0_write;
    logic              avs_s0_read;
    logic [31:0]       avs_s0_readdata;

    logic [ADDR_W-1:0] avm_m0_address;
    logic              avm_m0_read;
    logic [15:0]       avm_m0_burstcount;
    logic              avm_m0_waitrequest;
    logic [DATA_W-1:0] avm_m0_readdata;
    logic              avm_m0_readdatavalid;

    logic [ADDR_W-1:0] avm_m1_address;
    logic              avm_m1_write;
    logic [DATA_W-1:0] avm_m1_writedata;
    logic [15:0]       avm_m1_burstcount;
    logic              avm_m1_waitrequest;

    modport master (
        input  avs_s0_address, avs_s0_writedata, avs_s0_write, avs_s0_read,
        output avs_s0_readdata,
        output avm_m0_address, avm_m0_read, avm_m0_burstcount,
        input  avm_m0_waitrequest, avm_m0_readdata, avm_m0_readdatavalid,
        output avm_m1_address, avm_m1_write, avm_m1_writedata, avm_m1_burstcount,
        input  avm_m1_waitrequest
    );

    modport slave (
        output avs_s0_address, avs_s0_writedata, avs_s0_write, avs_s0_read,
        input  avs_s0_readdata,
        input  avm_m0_address, avm_m0_read, avm_m0_burstcount,
        output avm_m0_waitrequest, avm_m0_readdata, avm_m0_readdatavalid,
        input  avm_m1_address, avm_m1_write, avm_m1_writedata, avm_m1_burstcount,
        output avm_m1_waitrequest
    );
endinterface

// File: rtl/bpfcap_dma_engine.sv
// Single-channel memory-to-memory burst copy engine with CSR bank and internal FIFO.
// Optional interrupt output and IRQ_CTRL CSR when BPFCAP_DMA_IRQ_EN is defined.
`timescale 1ns/1ps
module bpfcap_dma_engine #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    bpfcap_dma_engine_if.master     bus
`ifdef BPFCAP_DMA_IRQ_EN
    ,
    output logic                    irq
`endif
);
    localparam int unsigned LB = $clog2(DATA_W / 8);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDone = 2'd2, StError = 2'd3} state_e;

    state_e            state_q;
    logic [31:0]       src_begin_q, src_end_q, dst_addr_q, word_cnt_q, readdata_q;
    logic              len_err_q, swb_q, abort_q;
    logic [ADDR_W-1:0] rd_addr_q, rd_remain_q, wr_addr_q, wr_remain_q;
    logic [ADDR_W-1:0] m0_addr_q, m1_addr_q;
    logic              rd_pend_q, m0_read_q, wr_active_q, m1_write_q;
    logic [15:0]       rd_left_q, wr_left_q, m0_bc_q, m1_bc_q;
    logic [PW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic              ctrl_wr, start_req, abort_req, len_bad, rd_go, wr_go;
    logic              push, pop, job_done;
    logic [ADDR_W-1:0] len;
    logic [15:0]       rd_b, wr_b;
    logic [CW-1:0]     free;
    logic [31:0]       rdata_d;

    always_comb begin
        ctrl_wr   = bus.avs_s0_write && (bus.avs_s0_address == 3'd0);
        abort_req = ctrl_wr && bus.avs_s0_writedata[1];
        start_req = ctrl_wr && bus.avs_s0_writedata[0] && !bus.avs_s0_writedata[1];
        len       = src_end_q[ADDR_W-1:0] - src_begin_q[ADDR_W-1:0];
        len_bad   = (len == '0) || (len[LB-1:0] != '0);
        rd_b      = (rd_remain_q > ADDR_W'(MAX_BURST)) ? 16'(MAX_BURST) : 16'(rd_remain_q);
        wr_b      = (wr_remain_q > ADDR_W'(MAX_BURST)) ? 16'(MAX_BURST) : 16'(wr_remain_q);
        free      = CW'(FIFO_DEPTH) - cnt_q;
        // A read burst is only issued once the previous one has fully returned, so
        // the FIFO free space seen here already accounts for every in-flight word.
        rd_go     = (state_q == StRun) && !abort_q && !abort_req && !rd_pend_q &&
                    (rd_remain_q != '0) && (16'(free) >= rd_b);
        wr_go     = (state_q == StRun) && !abort_q && !abort_req && !wr_active_q &&
                    (wr_remain_q != '0) && (16'(cnt_q) >= wr_b);
        push      = rd_pend_q && bus.avm_m0_readdatavalid && !abort_q;
        pop       = m1_write_q && !bus.avm_m1_waitrequest;
        job_done  = pop && (wr_remain_q == ADDR_W'(1));
    end

`ifdef BPFCAP_DMA_IRQ_EN
    logic irq_en_q, irq_pend_q, irq_q, fin_entry;
    assign fin_entry = ((state_q != StRun) && start_req && len_bad) ||
                       ((state_q == StRun) && job_done);
    assign irq = irq_q;
`endif

    always_comb begin
        rdata_d = '0;
        case (bus.avs_s0_address)
            3'd1:    rdata_d = src_begin_q;
            3'd2:    rdata_d = src_end_q;
            3'd3:    rdata_d = dst_addr_q;
            3'd4:    rdata_d = {27'd0, swb_q, len_err_q, state_q == StRun, state_q};
            3'd5:    rdata_d = word_cnt_q;
`ifdef BPFCAP_DMA_IRQ_EN
            3'd6:    rdata_d = {30'd0, irq_pend_q, irq_en_q};
`endif
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= bus.avm_m0_readdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            src_begin_q <= '0;
            src_end_q   <= '0;
            dst_addr_q  <= '0;
            word_cnt_q  <= '0;
            readdata_q  <= '0;
            len_err_q   <= 1'b0;
            swb_q       <= 1'b0;
            abort_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_remain_q <= '0;
            wr_addr_q   <= '0;
            wr_remain_q <= '0;
            m0_addr_q   <= '0;
            m1_addr_q   <= '0;
            rd_pend_q   <= 1'b0;
            m0_read_q   <= 1'b0;
            wr_active_q <= 1'b0;
            m1_write_q  <= 1'b0;
            rd_left_q   <= '0;
            wr_left_q   <= '0;
            m0_bc_q     <= '0;
            m1_bc_q     <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
`ifdef BPFCAP_DMA_IRQ_EN
            irq_en_q    <= 1'b0;
            irq_pend_q  <= 1'b0;
            irq_q       <= 1'b0;
`endif
        end else begin
            if (bus.avs_s0_read) readdata_q <= rdata_d;
            if (bus.avs_s0_write) begin
                case (bus.avs_s0_address)
                    3'd1:    src_begin_q <= bus.avs_s0_writedata;
                    3'd2:    src_end_q   <= bus.avs_s0_writedata;
                    3'd3:    dst_addr_q  <= bus.avs_s0_writedata;
                    default: ;
                endcase
            end

            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase

            if (rd_go) begin
                m0_read_q   <= 1'b1;
                m0_addr_q   <= rd_addr_q;
                m0_bc_q     <= rd_b;
                rd_pend_q   <= 1'b1;
                rd_left_q   <= rd_b;
                rd_addr_q   <= rd_addr_q + (ADDR_W'(rd_b) << LB);
                rd_remain_q <= rd_remain_q - ADDR_W'(rd_b);
            end else if (m0_read_q && !bus.avm_m0_waitrequest) begin
                m0_read_q <= 1'b0;
            end
            if (rd_pend_q && bus.avm_m0_readdatavalid) begin
                rd_left_q <= rd_left_q - 1'b1;
                if (rd_left_q == 16'd1) rd_pend_q <= 1'b0;
            end

            if (wr_go) begin
                m1_write_q  <= 1'b1;
                m1_addr_q   <= wr_addr_q;
                m1_bc_q     <= wr_b;
                wr_active_q <= 1'b1;
                wr_left_q   <= wr_b;
            end else if (pop) begin
                word_cnt_q  <= word_cnt_q + 1'b1;
                wr_remain_q <= wr_remain_q - 1'b1;
                wr_left_q   <= wr_left_q - 1'b1;
                if (wr_left_q == 16'd1) begin
                    m1_write_q  <= 1'b0;
                    wr_active_q <= 1'b0;
                    wr_addr_q   <= wr_addr_q + (ADDR_W'(m1_bc_q) << LB);
                end
            end

            case (state_q)
                StRun: begin
                    if (start_req) swb_q <= 1'b1;
                    if (abort_req) abort_q <= 1'b1;
                    if (job_done) begin
                        state_q <= StDone;
                        abort_q <= 1'b0;
                    end else if (abort_q && !rd_pend_q && !wr_active_q) begin
                        // Both masters are quiet: drop whatever the FIFO still holds.
                        state_q <= StIdle;
                        abort_q <= 1'b0;
                        wp_q    <= '0;
                        rp_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (start_req) begin
                        swb_q       <= 1'b0;
                        word_cnt_q  <= '0;
                        rd_addr_q   <= src_begin_q[ADDR_W-1:0];
                        wr_addr_q   <= dst_addr_q[ADDR_W-1:0];
                        rd_remain_q <= len >> LB;
                        wr_remain_q <= len >> LB;
                        len_err_q   <= len_bad;
                        state_q     <= len_bad ? StError : StRun;
                    end
                end
            endcase

`ifdef BPFCAP_DMA_IRQ_EN
            if (bus.avs_s0_write && (bus.avs_s0_address == 3'd6)) begin
                irq_en_q <= bus.avs_s0_writedata[0];
                if (bus.avs_s0_writedata[1]) irq_pend_q <= 1'b0;
            end
            if (fin_entry) irq_pend_q <= 1'b1;
            irq_q <= irq_en_q & irq_pend_q;
`endif
        end
    end

    assign bus.avs_s0_readdata   = readdata_q;
    assign bus.avm_m0_address    = m0_addr_q;
    assign bus.avm_m0_read       = m0_read_q;
    assign bus.avm_m0_burstcount = m0_bc_q;
    assign bus.avm_m1_address    = m1_addr_q;
    assign bus.avm_m1_write      = m1_write_q;
    assign bus.avm_m1_burstcount = m1_bc_q;
    assign bus.avm_m1_writedata  = m1_write_q ? mem[rp_q] : '0;
endmodule

// File: tb/tb_bpfcap_dma_engine.sv
// Directed bench for bpfcap_dma_engine with behavioural Avalon read/write memories.
`timescale 1ns/1ps
module tb_bpfcap_dma_engine;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bpfcap_dma_engine_if #(.DATA_W(32), .ADDR_W(32)) bus ();
`ifdef BPFCAP_DMA_IRQ_EN
    logic irq;
`endif

    bpfcap_dma_engine #(.DATA_W(32), .FIFO_DEPTH(256), .MAX_BURST(16), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BPFCAP_DMA_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    int total = 0;
    int bad = 0;
    logic stall_en = 1'b0;
    logic rd_hold = 1'b0;
    logic [31:0] dst_base = 32'h0;
    int viol = 0;
    int rd_req_cycles = 0;
    int wr_req_cycles = 0;

    logic [31:0] rd_log_a[$];
    logic [15:0] rd_log_b[$];
    logic [31:0] wr_log_a[$];
    logic [15:0] wr_log_b[$];
    logic [31:0] rsp_q[$];
    logic [31:0] wmem [0:255];

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return (~a) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read memory: samples on negedge, answers one word per cycle after acceptance.
    logic        p_read = 1'b0, p_wait = 1'b0;
    logic [31:0] p_addr = '0;
    logic [15:0] p_bc = '0;
    always @(negedge clk) begin
        if (reset) begin
            if (p_read && !p_wait) begin
                rd_log_a.push_back(p_addr);
                rd_log_b.push_back(p_bc);
                for (int k = 0; k < int'(p_bc); k++) rsp_q.push_back(p_addr + 32'(k * 4));
            end
            if (p_read && p_wait && (!bus.avm_m0_read || bus.avm_m0_address !== p_addr ||
                                     bus.avm_m0_burstcount !== p_bc)) viol++;
            if (bus.avm_m0_read) rd_req_cycles++;
            p_read = bus.avm_m0_read;
            p_addr = bus.avm_m0_address;
            p_bc   = bus.avm_m0_burstcount;
            p_wait = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.avm_m0_waitrequest = p_wait;
            if (!rd_hold && rsp_q.size() > 0) begin
                bus.avm_m0_readdatavalid = 1'b1;
                bus.avm_m0_readdata      = src_word(rsp_q.pop_front());
            end else begin
                bus.avm_m0_readdatavalid = 1'b0;
                bus.avm_m0_readdata      = '0;
            end
        end
    end

    // Write memory: records bursts and data, flags any change while stalled.
    logic        q_write = 1'b0, q_wait = 1'b0;
    logic [31:0] q_addr = '0, q_data = '0, b_base = '0;
    logic [15:0] q_bc = '0, b_bc = '0;
    int          beat = 0;
    always @(negedge clk) begin
        if (reset) begin
            if (q_write && !q_wait) begin
                int idx;
                if (beat == 0) begin
                    b_base = q_addr;
                    b_bc   = q_bc;
                    wr_log_a.push_back(q_addr);
                    wr_log_b.push_back(q_bc);
                end else if (q_addr !== b_base || q_bc !== b_bc) viol++;
                idx = int'((b_base - dst_base) >> 2) + beat;
                if (idx >= 0 && idx < 256) wmem[idx] = q_data;
                else viol++;
                beat++;
                if (beat >= int'(b_bc)) beat = 0;
            end
            if (q_write && q_wait && (!bus.avm_m1_write || bus.avm_m1_address !== q_addr ||
                bus.avm_m1_burstcount !== q_bc || bus.avm_m1_writedata !== q_data)) viol++;
            if (beat != 0 && !bus.avm_m1_write) viol++;
            if (bus.avm_m1_write) wr_req_cycles++;
            q_write = bus.avm_m1_write;
            q_addr  = bus.avm_m1_address;
            q_bc    = bus.avm_m1_burstcount;
            q_data  = bus.avm_m1_writedata;
            q_wait  = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.avm_m1_waitrequest = q_wait;
        end
    end

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.avs_s0_address = a; bus.avs_s0_writedata = d; bus.avs_s0_write = 1'b1;
        @(posedge clk); #1;
        bus.avs_s0_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.avs_s0_address = a; bus.avs_s0_read = 1'b1;
        @(posedge clk); #1;
        bus.avs_s0_read = 1'b0;
        d = bus.avs_s0_readdata;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        for (int i = 0; i < 3000; i++) begin
            csr_rd(3'd4, st);
            if (st[1:0] != 2'd1) break;
        end
    endtask

    task automatic prep(input logic [31:0] src, input logic [31:0] src_end, input logic [31:0] dst);
        rd_log_a.delete(); rd_log_b.delete(); wr_log_a.delete(); wr_log_b.delete();
        viol = 0; rd_req_cycles = 0; wr_req_cycles = 0;
        for (int i = 0; i < 256; i++) wmem[i] = 32'hDEAD_BEEF;
        dst_base = dst;
        csr_wr(3'd1, src);
        csr_wr(3'd2, src_end);
        csr_wr(3'd3, dst);
    endtask

    task automatic check_data(input string tag, input logic [31:0] src, input int n);
        int mm = 0;
        for (int i = 0; i < n; i++) if (wmem[i] !== src_word(src + 32'(i * 4))) mm++;
        check(tag, 32'(mm), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] r;
    int          wrong;
    initial begin
        bus.avs_s0_address = '0; bus.avs_s0_writedata = '0;
        bus.avs_s0_write = 1'b0; bus.avs_s0_read = 1'b0;
        bus.avm_m0_waitrequest = 1'b0; bus.avm_m0_readdatavalid = 1'b0;
        bus.avm_m0_readdata = '0; bus.avm_m1_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m0_read", 32'(bus.avm_m0_read), 32'd0);
        check("rst_m1_write", 32'(bus.avm_m1_write), 32'd0);
        check("rst_m0_addr", bus.avm_m0_address | 32'(bus.avm_m0_burstcount), 32'd0);
        check("rst_m1_addr", bus.avm_m1_address | 32'(bus.avm_m1_burstcount), 32'd0);
        check("rst_wdata", bus.avm_m1_writedata | bus.avs_s0_readdata, 32'd0);
        reset = 1'b1;
        csr_rd(3'd4, r); check("rst_status", r, 32'd0);
        csr_rd(3'd5, r); check("rst_wordcnt", r, 32'd0);
        csr_rd(3'd1, r); check("rst_src_begin", r, 32'd0);
        csr_wr(3'd1, 32'h1234_5678);
        csr_rd(3'd1, r); check("src_begin_rw", r, 32'h1234_5678);
        csr_rd(3'd0, r); check("control_reads0", r, 32'd0);

        // 64 words, no stalls
        prep(32'h1000, 32'h1100, 32'h8000);
        csr_wr(3'd0, 32'd1);
        wait_idle(r);
        check("t1_status", r, 32'h2);
        csr_rd(3'd5, r); check("t1_wordcnt", r, 32'd64);
        check("t1_rd_bursts", 32'(rd_log_a.size()), 32'd4);
        check("t1_rd_addr0", rd_log_a[0], 32'h1000);
        check("t1_rd_addr1", rd_log_a[1], 32'h1040);
        check("t1_rd_addr3", rd_log_a[3], 32'h10C0);
        check("t1_wr_bursts", 32'(wr_log_a.size()), 32'd4);
        check("t1_wr_addr0", wr_log_a[0], 32'h8000);
        check("t1_wr_addr3", wr_log_a[3], 32'h80C0);
        wrong = 0;
        foreach (rd_log_b[i]) if (rd_log_b[i] !== 16'd16) wrong++;
        foreach (wr_log_b[i]) if (wr_log_b[i] !== 16'd16) wrong++;
        check("t1_bc16", 32'(wrong), 32'd0);
        check_data("t1_data", 32'h1000, 64);
        check("t1_viol", 32'(viol), 32'd0);

        // 5 words, single short burst
        prep(32'h2000, 32'h2014, 32'h9000);
        csr_wr(3'd0, 32'd1);
        wait_idle(r);
        check("t2_status", r, 32'h2);
        csr_rd(3'd5, r); check("t2_wordcnt", r, 32'd5);
        check("t2_rd_bursts", 32'(rd_log_a.size()), 32'd1);
        check("t2_rd_bc", 32'(rd_log_b[0]), 32'd5);
        check("t2_rd_addr", rd_log_a[0], 32'h2000);
        check("t2_wr_bc", 32'(wr_log_b[0]), 32'd5);
        check("t2_wr_addr", wr_log_a[0], 32'h9000);
        check_data("t2_data", 32'h2000, 5);

        // zero length and misaligned length
        prep(32'h3000, 32'h3000, 32'hA000);
        csr_wr(3'd0, 32'd1);
        repeat (5) @(posedge clk);
        csr_rd(3'd4, r); check("t3_status", r, 32'h0B);
        csr_rd(3'd5, r); check("t3_wordcnt", r, 32'd0);
        check("t3_no_bus", 32'(rd_req_cycles + wr_req_cycles), 32'd0);
        prep(32'h3000, 32'h3006, 32'hA000);
        csr_wr(3'd0, 32'd1);
        repeat (5) @(posedge clk);
        csr_rd(3'd4, r); check("t3_misalign", r, 32'h0B);
        check("t3_misalign_bus", 32'(rd_req_cycles + wr_req_cycles), 32'd0);

        // 200 words with random stalls on both masters
        stall_en = 1'b1;
        prep(32'h4000, 32'h4320, 32'hA000);
        csr_wr(3'd0, 32'd1);
        wait_idle(r);
        stall_en = 1'b0;
        check("t4_status", r, 32'h2);
        csr_rd(3'd5, r); check("t4_wordcnt", r, 32'd200);
        check("t4_viol", 32'(viol), 32'd0);
        check_data("t4_data", 32'h4000, 200);
        check("t4_rd_bursts", 32'(rd_log_a.size()), 32'd13);
        check("t4_rd_last_bc", 32'(rd_log_b[12]), 32'd8);
        check("t4_wr_bursts", 32'(wr_log_a.size()), 32'd13);

        // abort with a read burst outstanding, after a start-while-busy
        rd_hold = 1'b1;
        prep(32'h5000, 32'h5100, 32'hB000);
        csr_wr(3'd0, 32'd1);
        repeat (4) @(posedge clk);
        csr_wr(3'd0, 32'd1);
        csr_rd(3'd4, r); check("t5_busy_swb", r, 32'h15);
        check("t5_one_read", 32'(rd_log_a.size()), 32'd1);
        csr_wr(3'd0, 32'd2);
        repeat (5) @(posedge clk);
        csr_rd(3'd4, r); check("t5_wait_inflight", r, 32'h15);
        rd_hold = 1'b0;
        repeat (40) @(posedge clk);
        csr_rd(3'd4, r); check("t5_idle", r, 32'h10);
        check("t5_no_more_reads", 32'(rd_log_a.size()), 32'd1);
        check("t5_no_writes", 32'(wr_log_a.size()), 32'd0);
        csr_rd(3'd5, r); check("t5_wordcnt", r, 32'd0);
        prep(32'h2000, 32'h2014, 32'h9000);
        csr_wr(3'd0, 32'd1);
        wait_idle(r);
        check("t5_after_status", r, 32'h2);
        csr_rd(3'd5, r); check("t5_after_wordcnt", r, 32'd5);
        check_data("t5_after_data", 32'h2000, 5);

`ifdef BPFCAP_DMA_IRQ_EN
        csr_wr(3'd6, 32'd1);
        prep(32'h6000, 32'h6040, 32'hC000);
        csr_wr(3'd0, 32'd1);
        wait_idle(r);
        check("t6_status", r, 32'h2);
        repeat (2) @(posedge clk);
        #1;
        check("t6_irq_high", 32'(irq), 32'd1);
        csr_rd(3'd6, r); check("t6_irqctrl", r, 32'd3);
        csr_wr(3'd6, 32'd3);
        repeat (2) @(posedge clk);
        #1;
        check("t6_irq_low", 32'(irq), 32'd0);
`else
        csr_wr(3'd6, 32'hFFFF_FFFF);
        csr_rd(3'd6, r); check("t6_csr6_zero", r, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bpfcap_dma_engine.md
Name: bpfcap_dma_engine

Overview:
- Parametrised successor of the capture top: a single-channel memory-to-memory packet copy engine with its own CSR bank, Avalon-MM burst read master, internal FIFO and Avalon-MM burst write master.
- Software programs a source window and a destination, then starts the copy. The engine moves the window in bursts and reports status and word count.
- Adds what the previous generation lacked: full waitrequest support, parametrised width, depth and burst length, length checking, abort, and a word counter.

Parameters:
- DATA_W, 32, data bus width in bits; power of two, 32..128.
- FIFO_DEPTH, 256, internal FIFO depth in words; power of two, at least 2*MAX_BURST.
- MAX_BURST, 16, maximum burstcount per transaction; power of two, 1..64.
- ADDR_W, 32, byte address width of both masters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- avs_s0_address  in  3  CSR word index
- avs_s0_writedata  in  32  CSR write data
- avs_s0_write  in  1  CSR write strobe
- avs_s0_read  in  1  CSR read strobe
- avs_s0_readdata  out  32  CSR read data, registered
- avm_m0_address  out  ADDR_W  read master byte address
- avm_m0_read  out  1  read request
- avm_m0_burstcount  out  16  read burst length
- avm_m0_waitrequest  in  1  read stall
- avm_m0_readdata  in  DATA_W  read data
- avm_m0_readdatavalid  in  1  read data valid
- avm_m1_address  out  ADDR_W  write master byte address
- avm_m1_write  out  1  write request
- avm_m1_writedata  out  DATA_W  write data (FIFO head)
- avm_m1_burstcount  out  16  write burst length
- avm_m1_waitrequest  in  1  write stall

Behaviour:
- Reset: asynchronous, active-low. Every output is 0, all CSRs are 0, the FIFO is empty, and the FSM is IDLE.
- CSRs, all 32-bit; reads return data on the cycle after avs_s0_read:
  - 0 CONTROL (W): bit0 START, bit1 ABORT. Self-clearing; reads return 0.
  - 1 SRC_BEGIN (RW)
  - 2 SRC_END (RW, exclusive)
  - 3 DST_ADDR (RW)
  - 4 STATUS (R): [1:0] state, bit2 busy, bit3 len_err, bit4 start_while_busy (sticky, cleared by START in IDLE/DONE/ERROR).
  - 5 WORD_COUNT (R): words written in the current or last job.
- FSM states: IDLE=0, RUN=1, DONE=2, ERROR=3.
- START in IDLE, DONE or ERROR:
  - Latch the registers and clear WORD_COUNT.
  - len = SRC_END - SRC_BEGIN (ADDR_W modular arithmetic).
  - len = 0, or len not a multiple of DATA_W/8 → ERROR with len_err=1, no bus traffic, next cycle.
  - Otherwise → RUN.
- START in RUN: ignored, start_while_busy set.
- Read master:
  - In RUN, issues a burst only when no read burst is outstanding, read words remain, and FIFO free space ≥ b. b = min(MAX_BURST, remaining read words).
  - Address, read and burstcount are held stable while waitrequest=1.
  - The request completes on read && !waitrequest. The address advances b*DATA_W/8.
  - Each readdatavalid pushes one word. The FIFO never overflows by construction.
- Write master:
  - In RUN, issues a burst when no write burst is active and FIFO count ≥ w. w = min(MAX_BURST, remaining write words).
  - write is held high for w beats. Each beat with !waitrequest pops the FIFO, increments WORD_COUNT and presents the next head.
  - Address and burstcount are presented with the first beat, then held for the rest of the burst.
- RUN → DONE when the remaining write words reach 0 and the last beat is accepted.
- Simultaneous FIFO push and pop in one cycle: count unchanged.
- ABORT in RUN:
  - No new bursts are issued.
  - The outstanding read burst is completed; its data is discarded.
  - The active write burst completes with FIFO data.
  - Then the FIFO is flushed and the FSM goes to IDLE.
- ABORT in other states: no effect.
- Simultaneous START and ABORT: ABORT wins.
- Reset asserted mid-transfer: immediate return to reset values; bus contracts are not honoured.

Optional Feature:
- Macro: BPFCAP_DMA_IRQ_EN.
- When defined:
  - Adds port irq (out, 1).
  - Adds CSR 6 IRQ_CTRL: bit0 enable; writing 1 to bit1 clears pending.
  - Pending is set on entry to DONE or ERROR.
  - irq = enable & pending, registered.
- When undefined: no port, CSR 6 reads 0 and writes are ignored.

Test Plan:
- DATA_W=32, MAX_BURST=16. SRC 0x1000..0x1100, DST 0x8000, START, no stalls → read bursts of 16 at 0x1000 and 0x1040..0x10C0; 64 words written from 0x8000 in order; STATUS state=2; WORD_COUNT=64.
- SRC 0x2000..0x2014 (5 words) → single burstcount=5 on each master; DONE; WORD_COUNT=5.
- SRC_END=SRC_BEGIN=0x3000, START → ERROR, len_err=1, zero bus activity.
- Random waitrequest at 50% on both masters, 200-word job → address, burstcount and writedata stable during stalls; data bit-exact; WORD_COUNT=200.
- ABORT mid-job with a read burst outstanding → in-flight bursts complete, no further requests, FIFO empty, state=0; a second START in RUN beforehand sets start_while_busy.
- With BPFCAP_DMA_IRQ_EN: enable, run a 16-word job → irq rises after DONE, falls after the clear write.
